// File: rtl/cpu_pkg.sv
// Shared types and widths for the memory stage.
package cpu_pkg;

  localparam int WORD_W   = 32;
  localparam int REGNUM_W = 5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  // MEM/WB pipeline register contents
  typedef struct packed {
    logic                wreg;
    logic                m2reg;
    logic [WORD_W-1:0]   mo;
    logic [WORD_W-1:0]   alu;
    logic [REGNUM_W-1:0] rn;
  } mem_wb_t;

  // Byte address to word-aligned address
  function automatic logic [WORD_W-1:0] word_addr(input logic [WORD_W-1:0] a);
    return {a[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-memory req/ack port. master = memory-stage controller, slave = memory.
interface mem_access_ctrl_if
  import cpu_pkg::*;
();

  logic              dmem_req;
  logic              dmem_we;
  logic [WORD_W-1:0] dmem_addr;
  logic [WORD_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [WORD_W-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );

endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: load takes a full record, bubble clears the
// write-back controls and leaves the data fields untouched.
module mem_wb_reg
  import cpu_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    load,
  input  logic    bubble,
  input  mem_wb_t d,
  output mem_wb_t q
);

  // Register with async clear; load has priority over bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (bubble) begin
      q.wreg  <= 1'b0;
      q.m2reg <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage controller: issues req/ack data-memory accesses for loads and
// stores, stalls the front of the pipeline while an access is outstanding,
// and feeds the MEM/WB register.
// Optional: define MEM_TIMEOUT_EN to abort accesses that see no ack within
// TIMEOUT_CYCLES busy cycles (timeout_err pulses in the abort cycle).
module mem_access_ctrl
  import cpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mwreg,
  input  logic                mm2reg,
  input  logic                mwmem,
  input  logic [WORD_W-1:0]   malu,
  input  logic [REGNUM_W-1:0] mrn,
  input  logic [WORD_W-1:0]   di,
  mem_access_ctrl_if.master   dmem,
  output logic                stall,
  output logic                wwreg,
  output logic                wm2reg,
  output logic [WORD_W-1:0]   wmo,
  output logic [WORD_W-1:0]   walu,
  output logic [REGNUM_W-1:0] wrn,
  output logic                timeout_err
);

  if (TIMEOUT_CYCLES < 2 || (64'(1) << CNT_W) <= 64'(TIMEOUT_CYCLES)) begin : g_bad_param
    $error("mem_access_ctrl: TIMEOUT_CYCLES must be >= 2 and < 2**CNT_W");
  end

  mem_state_t          state_reg, state_next;
  logic                req_reg, we_reg;
  logic [WORD_W-1:0]   addr_reg, wdata_reg, alu_reg;
  logic                wreg_reg, m2reg_reg;
  logic [REGNUM_W-1:0] rn_reg;
  logic                acc, abort;
  logic                wb_load, wb_bubble;
  mem_wb_t             wb_d, wb_q;

  // A store wins when both load and store are flagged
  assign acc = mwmem | mm2reg;

`ifdef MEM_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_reg;

  // Busy-cycle counter; held at zero while idle so every access starts at 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (state_reg == IDLE) begin
      cnt_reg <= '0;
    end else if (!dmem.dmem_ack) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  // An ack in the last allowed cycle completes normally instead of aborting
  assign abort = (state_reg == BUSY) && !dmem.dmem_ack &&
                 (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign abort = 1'b0;
`endif

  assign timeout_err = abort;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next state, stall and MEM/WB load selection
  always_comb begin
    state_next = state_reg;
    stall      = 1'b0;
    wb_load    = 1'b0;
    wb_bubble  = 1'b0;
    wb_d       = '0;
    case (state_reg)
      IDLE: begin
        if (acc) begin
          stall      = 1'b1;
          wb_bubble  = 1'b1;
          state_next = BUSY;
        end else begin
          wb_load    = 1'b1;
          wb_d.wreg  = mwreg;
          wb_d.alu   = malu;
          wb_d.rn    = mrn;
        end
      end
      BUSY: begin
        if (dmem.dmem_ack) begin
          wb_load    = 1'b1;
          wb_d.wreg  = wreg_reg;
          wb_d.m2reg = m2reg_reg;
          wb_d.mo    = m2reg_reg ? dmem.dmem_rdata : '0;
          wb_d.alu   = alu_reg;
          wb_d.rn    = rn_reg;
          state_next = IDLE;
        end else if (abort) begin
          // wreg stays 0 so a load that never returned is not written back
          wb_load    = 1'b1;
          wb_d.alu   = alu_reg;
          wb_d.rn    = rn_reg;
          state_next = IDLE;
        end else begin
          stall      = 1'b1;
          wb_bubble  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture the access at issue; EX/MEM is frozen, but the port must not
  // depend on upstream behaviour while the request is outstanding
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_reg   <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      wreg_reg  <= 1'b0;
      m2reg_reg <= 1'b0;
      alu_reg   <= '0;
      rn_reg    <= '0;
    end else begin
      req_reg <= (state_next == BUSY);
      if (state_reg == IDLE && acc) begin
        we_reg    <= mwmem;
        addr_reg  <= word_addr(malu);
        wdata_reg <= di;
        wreg_reg  <= mwreg;
        m2reg_reg <= mm2reg & ~mwmem;
        alu_reg   <= malu;
        rn_reg    <= mrn;
      end
    end
  end

  assign dmem.dmem_req   = req_reg;
  assign dmem.dmem_we    = we_reg;
  assign dmem.dmem_addr  = addr_reg;
  assign dmem.dmem_wdata = wdata_reg;

  mem_wb_reg u_mem_wb_reg (
    .clk    (clk),
    .rst    (rst),
    .load   (wb_load),
    .bubble (wb_bubble),
    .d      (wb_d),
    .q      (wb_q)
  );

  assign wwreg  = wb_q.wreg;
  assign wm2reg = wb_q.m2reg;
  assign wmo    = wb_q.mo;
  assign walu   = wb_q.alu;
  assign wrn    = wb_q.rn;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: reset checks, a table of directed transactions,
// reset during an access, random transactions against a transaction-level
// model, and (with MEM_TIMEOUT_EN) the abort path with TIMEOUT_CYCLES=4.
module tb_mem_access_ctrl;

  typedef struct {
    logic        mwreg;
    logic        mm2reg;
    logic        mwmem;
    logic [31:0] malu;
    logic [4:0]  mrn;
    logic [31:0] di;
    int          delay;     // BUSY cycles without ack before the ack cycle
    logic [31:0] rdata;
    logic        stray;     // ack pulse while idle (non-memory ops only)
    logic        e_acc;
    logic        e_we;
    logic [31:0] e_addr;
    logic        e_wwreg;
    logic        e_wm2reg;
    logic [31:0] e_wmo;
    logic [31:0] e_walu;
    logic [4:0]  e_wrn;
  } vec_t;

  logic        clk, rst;
  logic        mwreg, mm2reg, mwmem;
  logic [31:0] malu, di;
  logic [4:0]  mrn;
  logic        stall, wwreg, wm2reg, timeout_err;
  logic [31:0] wmo, walu;
  logic [4:0]  wrn;

  int total = 0;
  int bad   = 0;

  mem_access_ctrl_if dmem_bus ();

  mem_access_ctrl #(
`ifdef MEM_TIMEOUT_EN
    .TIMEOUT_CYCLES (4),
    .CNT_W          (3)
`else
    .TIMEOUT_CYCLES (64),
    .CNT_W          (7)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mwreg       (mwreg),
    .mm2reg      (mm2reg),
    .mwmem       (mwmem),
    .malu        (malu),
    .mrn         (mrn),
    .di          (di),
    .dmem        (dmem_bus.master),
    .stall       (stall),
    .wwreg       (wwreg),
    .wm2reg      (wm2reg),
    .wmo         (wmo),
    .walu        (walu),
    .wrn         (wrn),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected outcome of one instruction, straight from the architectural rules
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    r.e_acc    = v.mwmem | v.mm2reg;
    r.e_we     = v.mwmem;
    r.e_addr   = (v.malu / 4) * 4;
    r.e_wwreg  = v.mwreg;
    r.e_wm2reg = v.mm2reg && !v.mwmem;
    r.e_wmo    = r.e_wm2reg ? v.rdata : 32'h0;
    r.e_walu   = v.malu;
    r.e_wrn    = v.mrn;
    return r;
  endfunction

  function automatic vec_t mk(input logic wr, input logic ld, input logic st,
                              input logic [31:0] a, input logic [4:0] rn,
                              input logic [31:0] d, input int dly,
                              input logic [31:0] rd, input logic stray);
    vec_t v;
    v.mwreg = wr; v.mm2reg = ld; v.mwmem = st; v.malu = a; v.mrn = rn;
    v.di = d; v.delay = dly; v.rdata = rd; v.stray = stray;
    v.e_acc = 0; v.e_we = 0; v.e_addr = 0; v.e_wwreg = 0; v.e_wm2reg = 0;
    v.e_wmo = 0; v.e_walu = 0; v.e_wrn = 0;
    return v;
  endfunction

  // Present one instruction starting right after an edge, run it to retirement
  task automatic run_vec(input int idx, input vec_t v);
    mwreg = v.mwreg; mm2reg = v.mm2reg; mwmem = v.mwmem;
    malu = v.malu; mrn = v.mrn; di = v.di;
    dmem_bus.dmem_ack = 1'b0;
    dmem_bus.dmem_rdata = 32'h0;
    if (!v.e_acc) begin
      dmem_bus.dmem_ack = v.stray;
      dmem_bus.dmem_rdata = v.rdata;
      #1;
      chk("stall_idle", 32'(stall), 32'(0));
      chk("terr_idle", 32'(timeout_err), 32'(0));
      step();
      dmem_bus.dmem_ack = 1'b0;
      chk("req_none", 32'(dmem_bus.dmem_req), 32'(0));
    end else begin
      #1;
      chk("stall_issue", 32'(stall), 32'(1));
      chk("req_issue", 32'(dmem_bus.dmem_req), 32'(0));
      step();
      chk("req_busy", 32'(dmem_bus.dmem_req), 32'(1));
      chk("we", 32'(dmem_bus.dmem_we), 32'(v.e_we));
      chk("addr", dmem_bus.dmem_addr, v.e_addr);
      if (v.e_we) chk("wdata", dmem_bus.dmem_wdata, v.di);
      chk("wwreg_bubble", 32'(wwreg), 32'(0));
      for (int i = 0; i < v.delay; i++) begin
        chk("stall_wait", 32'(stall), 32'(1));
        step();
        chk("req_hold", 32'(dmem_bus.dmem_req), 32'(1));
        chk("addr_hold", dmem_bus.dmem_addr, v.e_addr);
        chk("wwreg_wait", 32'(wwreg), 32'(0));
      end
      dmem_bus.dmem_ack = 1'b1;
      dmem_bus.dmem_rdata = v.rdata;
      #1;
      chk("stall_ack", 32'(stall), 32'(0));
      chk("terr_ack", 32'(timeout_err), 32'(0));
      step();
      dmem_bus.dmem_ack = 1'b0;
      chk("req_done", 32'(dmem_bus.dmem_req), 32'(0));
    end
    chk("wwreg", 32'(wwreg), 32'(v.e_wwreg));
    chk("wm2reg", 32'(wm2reg), 32'(v.e_wm2reg));
    chk("wmo", wmo, v.e_wmo);
    chk("walu", walu, v.e_walu);
    chk("wrn", 32'(wrn), 32'(v.e_wrn));
    $display("txn %0d acc=%0b we=%0b malu=%h rn=%0d delay=%0d -> wwreg=%0b wm2reg=%0b wmo=%h",
             idx, v.e_acc, v.e_we, v.malu, v.mrn, v.delay, wwreg, wm2reg, wmo);
  endtask

  task automatic chk_w_zero(input string tag);
    chk({tag, "_wwreg"}, 32'(wwreg), 32'(0));
    chk({tag, "_wm2reg"}, 32'(wm2reg), 32'(0));
    chk({tag, "_wmo"}, wmo, 32'h0);
    chk({tag, "_walu"}, walu, 32'h0);
    chk({tag, "_wrn"}, 32'(wrn), 32'(0));
  endtask

  vec_t tbl[6];

  initial begin
    vec_t v;

    // Directed table: inputs plus expected outputs written out by hand
    tbl[0] = mk(1, 0, 0, 32'h0000_1234, 5'd5, 32'h0, 0, 32'h0, 0);
    tbl[0].e_acc = 0; tbl[0].e_wwreg = 1; tbl[0].e_walu = 32'h1234; tbl[0].e_wrn = 5'd5;
    tbl[1] = mk(1, 1, 0, 32'h0000_0103, 5'd8, 32'h1111_1111, 3, 32'hDEAD_BEEF, 0);
    tbl[1].e_acc = 1; tbl[1].e_we = 0; tbl[1].e_addr = 32'h100; tbl[1].e_wwreg = 1;
    tbl[1].e_wm2reg = 1; tbl[1].e_wmo = 32'hDEAD_BEEF; tbl[1].e_walu = 32'h103; tbl[1].e_wrn = 5'd8;
    tbl[2] = mk(0, 0, 1, 32'h0000_0040, 5'd3, 32'hCAFE_F00D, 0, 32'h7777_7777, 0);
    tbl[2].e_acc = 1; tbl[2].e_we = 1; tbl[2].e_addr = 32'h40; tbl[2].e_walu = 32'h40; tbl[2].e_wrn = 5'd3;
    tbl[3] = mk(1, 1, 1, 32'h0000_7FF6, 5'd12, 32'h0000_55AA, 1, 32'h0000_0099, 0);
    tbl[3].e_acc = 1; tbl[3].e_we = 1; tbl[3].e_addr = 32'h7FF4; tbl[3].e_wwreg = 1;
    tbl[3].e_walu = 32'h7FF6; tbl[3].e_wrn = 5'd12;
    tbl[4] = mk(1, 0, 0, 32'hFFFF_FFFF, 5'd31, 32'h0, 0, 32'h1234_5678, 1);
    tbl[4].e_acc = 0; tbl[4].e_wwreg = 1; tbl[4].e_walu = 32'hFFFF_FFFF; tbl[4].e_wrn = 5'd31;
    tbl[5] = mk(0, 1, 0, 32'h0000_0008, 5'd0, 32'h0, 0, 32'h0BAD_F00D, 0);
    tbl[5].e_acc = 1; tbl[5].e_addr = 32'h8; tbl[5].e_wm2reg = 1; tbl[5].e_wmo = 32'h0BAD_F00D;
    tbl[5].e_walu = 32'h8;

    // Reset state
    rst = 1'b1;
    mwreg = 0; mm2reg = 0; mwmem = 0; malu = 0; mrn = 0; di = 0;
    dmem_bus.dmem_ack = 1'b0;
    dmem_bus.dmem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(dmem_bus.dmem_req), 32'(0));
    chk("rst_stall", 32'(stall), 32'(0));
    chk("rst_terr", 32'(timeout_err), 32'(0));
    chk_w_zero("rst");
    rst = 1'b0;
    step();

    for (int i = 0; i < 6; i++) run_vec(i, tbl[i]);

    // Reset while BUSY: request drops at once and the access is forgotten
    mwreg = 1; mm2reg = 1; mwmem = 0; malu = 32'h0000_0300; mrn = 5'd7;
    step();
    chk("rb_req", 32'(dmem_bus.dmem_req), 32'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("rb_req_drop", 32'(dmem_bus.dmem_req), 32'(0));
    chk_w_zero("rb");
    mwreg = 0; mm2reg = 0; malu = 0; mrn = 0;
    step();
    rst = 1'b0;
    dmem_bus.dmem_ack = 1'b1;
    dmem_bus.dmem_rdata = 32'hFFFF_0000;
    #1;
    chk("rb_stall", 32'(stall), 32'(0));
    step();
    dmem_bus.dmem_ack = 1'b0;
    chk("rb_stray_req", 32'(dmem_bus.dmem_req), 32'(0));
    chk_w_zero("rb_stray");
    $display("txn reset-mid-busy done");

`ifdef MEM_TIMEOUT_EN
    // Load that never gets an ack: abort in the 4th BUSY cycle
    mwreg = 1; mm2reg = 1; mwmem = 0; malu = 32'h0000_0200; mrn = 5'd9;
    #1;
    chk("to_stall_issue", 32'(stall), 32'(1));
    step();
    for (int i = 1; i <= 3; i++) begin
      chk("to_stall_wait", 32'(stall), 32'(1));
      chk("to_terr_wait", 32'(timeout_err), 32'(0));
      step();
    end
    chk("to_stall_abort", 32'(stall), 32'(0));
    chk("to_terr_abort", 32'(timeout_err), 32'(1));
    step();
    chk("to_req", 32'(dmem_bus.dmem_req), 32'(0));
    chk("to_wwreg", 32'(wwreg), 32'(0));
    chk("to_terr_after", 32'(timeout_err), 32'(0));
    $display("txn timeout abort done");
    run_vec(100, tbl[0]);
`endif

    // Random transactions checked against the model
    for (int n = 0; n < 200; n++) begin
      int kind = $urandom_range(0, 3);
      v = mk($urandom_range(0, 1) == 1, kind == 1 || kind == 3, kind == 2 || kind == 3,
             $urandom, 5'($urandom_range(0, 31)), $urandom, $urandom_range(0, 3),
             $urandom, $urandom_range(0, 1) == 1);
      v = model(v);
      run_vec(1000 + n, v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
